// File: rtl/rvv_vd_collect.sv
// Vector destination collector: merges tagged lane chunks into the old vd image and hands it to the VRF.
// Optional v0 element masking is compiled in when RVV_COLLECT_MASK_EN is defined.
module rvv_vd_collect #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             nb_chunks,
  input  logic [2:0]             vsew,
  input  logic                   mask_en,
  input  logic [VLEN-1:0]        v0,
  input  logic [VLEN-1:0]        vd_old,
  input  logic [NB_LANES-1:0]    lane_valid,
  input  logic [NB_LANES*64-1:0] lane_data,
  input  logic [NB_LANES*10-1:0] lane_index,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [VLEN-1:0]        wb_data,
  output logic [VLEN/8-1:0]      wb_be,
  output logic                   busy,
  output logic                   err
);

  localparam int W      = 1 << LANE_WIDTH;
  localparam int IDXW   = $clog2(VLEN);
  localparam int NBYTES = VLEN / 8;

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

  state_t state, state_next;

  logic [VLEN-1:0]   buffer_q, buffer_upd;
  logic [NBYTES-1:0] be_q, be_upd;
  logic [7:0]        remaining_q, remaining_upd;
  logic              err_q;
  logic              excess_err, range_err;
  logic [9:0]        lane_idx;
  logic              lane_keep;

`ifdef RVV_COLLECT_MASK_EN
  logic [2:0]        vsew_q;
  logic              mask_en_q;
  logic [VLEN-1:0]   v0_q;
  logic [9:0]        elem;
  logic              unused_ok;
  assign unused_ok = ^lane_data;
`else
  logic              unused_ok;
  assign unused_ok = ^{lane_data, mask_en, v0, vsew};
`endif

  // Merge this cycle's lanes in ascending order so a higher lane overwrites a lower one on the same index.
  always_comb begin
    buffer_upd    = buffer_q;
    be_upd        = be_q;
    remaining_upd = remaining_q;
    excess_err    = 1'b0;
    range_err     = 1'b0;
    lane_idx      = '0;
    lane_keep     = 1'b0;
`ifdef RVV_COLLECT_MASK_EN
    elem          = '0;
`endif
    for (int i = 0; i < NB_LANES; i++) begin
      lane_idx = lane_index[10*i +: 10];
`ifdef RVV_COLLECT_MASK_EN
      elem = lane_idx >> (4'(vsew_q) + 4'd3);
      if (!mask_en_q)
        lane_keep = 1'b1;
      else if ({1'b0, elem} >= 11'(VLEN))
        lane_keep = 1'b0;
      else
        lane_keep = v0_q[elem[IDXW-1:0]];
`else
      lane_keep = 1'b1;
`endif
      if (lane_valid[i]) begin
        if (remaining_upd == 8'd0) begin
          excess_err = 1'b1;
        end else begin
          remaining_upd = remaining_upd - 8'd1;
          if (({1'b0, lane_idx} + 11'(W)) > 11'(VLEN)) begin
            range_err = 1'b1;
          end else if (lane_keep) begin
            buffer_upd[lane_idx[IDXW-1:0] +: W]  = lane_data[64*i +: W];
            be_upd[lane_idx[IDXW-1:3] +: W/8]    = '1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (nb_chunks == 8'd0) ? COMMIT : COLLECT;
      COLLECT: if (remaining_upd == 8'd0) state_next = COMMIT;
      COMMIT:  if (wb_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wb_valid = (state == COMMIT);
    busy     = (state != IDLE);
  end

  // Stray lane traffic outside COLLECT is flagged; a new start clears the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      buffer_q    <= '0;
      be_q        <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
`ifdef RVV_COLLECT_MASK_EN
      vsew_q      <= '0;
      mask_en_q   <= 1'b0;
      v0_q        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            buffer_q    <= vd_old;
            be_q        <= '0;
            remaining_q <= nb_chunks;
            err_q       <= 1'b0;
`ifdef RVV_COLLECT_MASK_EN
            vsew_q      <= vsew;
            mask_en_q   <= mask_en;
            v0_q        <= v0;
`endif
          end else if (|lane_valid) begin
            err_q <= 1'b1;
          end
        end
        COLLECT: begin
          buffer_q    <= buffer_upd;
          be_q        <= be_upd;
          remaining_q <= remaining_upd;
          if (excess_err || range_err)
            err_q <= 1'b1;
        end
        COMMIT: begin
          if (|lane_valid)
            err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wb_data = buffer_q;
  assign wb_be   = be_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rvv_vd_collect.sv
// Directed self-checking bench for rvv_vd_collect (VLEN=128, byte lanes, two lanes).
module tb_rvv_vd_collect;

  logic         clk;
  logic         reset;
  logic         start;
  logic [7:0]   nb_chunks;
  logic [2:0]   vsew;
  logic         mask_en;
  logic [127:0] v0;
  logic [127:0] vd_old;
  logic [1:0]   lane_valid;
  logic [127:0] lane_data;
  logic [19:0]  lane_index;
  logic         wb_valid;
  logic         wb_ready;
  logic [127:0] wb_data;
  logic [15:0]  wb_be;
  logic         busy;
  logic         err;

  int testsRun;
  int testsFailed;

  rvv_vd_collect #(.VLEN(128), .LANE_WIDTH(3), .NB_LANES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .nb_chunks(nb_chunks), .vsew(vsew),
    .mask_en(mask_en), .v0(v0), .vd_old(vd_old), .lane_valid(lane_valid),
    .lane_data(lane_data), .lane_index(lane_index), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_data(wb_data), .wb_be(wb_be), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive both lanes for one clock edge, then idle them.
  task automatic applyStimulus(input logic [1:0] valid, input logic [9:0] idx0, input logic [7:0] d0,
                               input logic [9:0] idx1, input logic [7:0] d1);
    lane_valid = valid;
    lane_index = {idx1, idx0};
    lane_data  = {56'h0, d1, 56'h0, d0};
    tick();
    lane_valid = 2'b00;
  endtask

  task automatic startInstr(input logic [7:0] nb, input logic [2:0] sew, input logic msk,
                            input logic [127:0] mask, input logic [127:0] old);
    start     = 1'b1;
    nb_chunks = nb;
    vsew      = sew;
    mask_en   = msk;
    v0        = mask;
    vd_old    = old;
    tick();
    start     = 1'b0;
  endtask

  task automatic finishCommit();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b1; start = 1'b0; nb_chunks = '0; vsew = '0; mask_en = 1'b0;
    v0 = '0; vd_old = '0; lane_valid = '0; lane_data = '0; lane_index = '0; wb_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset_wb_valid", wb_valid, 1'b0);
    checkOutput("reset_wb_data", wb_data, 128'h0);
    checkOutput("reset_wb_be", wb_be, 16'h0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    reset = 1'b0;
    tick();

    // Unmasked byte chunks, two per cycle.
    startInstr(8'd16, 3'd0, 1'b0, 128'h0, 128'h0);
    checkOutput("t1_busy", busy, 1'b1);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(2'b11, 10'(16*c), 8'(8'h22*c), 10'(16*c+8), 8'(8'h22*c+8'h11));
      if (c == 6) checkOutput("t1_valid_early", wb_valid, 1'b0);
    end
    checkOutput("t1_wb_valid", wb_valid, 1'b1);
    checkOutput("t1_wb_data", wb_data, 128'hFFEEDDCCBBAA99887766554433221100);
    checkOutput("t1_wb_be", wb_be, 16'hFFFF);
    checkOutput("t1_err", err, 1'b0);
    finishCommit();
    checkOutput("t1_idle_valid", wb_valid, 1'b0);
    checkOutput("t1_idle_busy", busy, 1'b0);

    // Masked SEW=16, v0 selects even elements.
    startInstr(8'd16, 3'd1, 1'b1, 128'h55, {16{8'hAA}});
    for (int c = 0; c < 8; c++)
      applyStimulus(2'b11, 10'(16*c), 8'(8'h22*c), 10'(16*c+8), 8'(8'h22*c+8'h11));
    checkOutput("t2_wb_valid", wb_valid, 1'b1);
`ifdef RVV_COLLECT_MASK_EN
    checkOutput("t2_wb_data", wb_data, 128'hAAAADDCCAAAA9988AAAA5544AAAA1100);
    checkOutput("t2_wb_be", wb_be, 16'h3333);
`else
    checkOutput("t2_wb_data", wb_data, 128'hFFEEDDCCBBAA99887766554433221100);
    checkOutput("t2_wb_be", wb_be, 16'hFFFF);
`endif

    // Backpressure with a stray start; the committed image must not move.
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start = 1'b1; nb_chunks = 8'd0; vd_old = {128{1'b1}};
      end
      tick();
      start = 1'b0;
      checkOutput("t3_hold_valid", wb_valid, 1'b1);
`ifdef RVV_COLLECT_MASK_EN
      checkOutput("t3_hold_data", wb_data, 128'hAAAADDCCAAAA9988AAAA5544AAAA1100);
      checkOutput("t3_hold_be", wb_be, 16'h3333);
`else
      checkOutput("t3_hold_data", wb_data, 128'hFFEEDDCCBBAA99887766554433221100);
      checkOutput("t3_hold_be", wb_be, 16'hFFFF);
`endif
    end
    finishCommit();
    checkOutput("t3_idle_busy", busy, 1'b0);
    checkOutput("t3_idle_valid", wb_valid, 1'b0);
    checkOutput("t3_err", err, 1'b0);

    // Zero chunks: straight to commit with the old contents.
    startInstr(8'd0, 3'd0, 1'b0, 128'h0, 128'h123456789ABCDEF00FEDCBA987654321);
    checkOutput("t4_wb_valid", wb_valid, 1'b1);
    checkOutput("t4_wb_data", wb_data, 128'h123456789ABCDEF00FEDCBA987654321);
    checkOutput("t4_wb_be", wb_be, 16'h0);
    finishCommit();

    // Out-of-range chunk at index 128.
    startInstr(8'd4, 3'd0, 1'b0, 128'h0, 128'h0);
    applyStimulus(2'b11, 10'd0, 8'h01, 10'd8, 8'h02);
    applyStimulus(2'b11, 10'd128, 8'h03, 10'd16, 8'h04);
    checkOutput("t5_wb_valid", wb_valid, 1'b1);
    checkOutput("t5_wb_data", wb_data, 128'h040201);
    checkOutput("t5_wb_be", wb_be, 16'h0007);
    checkOutput("t5_err", err, 1'b1);
    tick();
    checkOutput("t5_err_held", err, 1'b1);
    finishCommit();

    // Reset after 3 of 16 chunks; start also clears the previous error.
    startInstr(8'd16, 3'd0, 1'b0, 128'h0, {16{8'h77}});
    checkOutput("t6_err_cleared", err, 1'b0);
    applyStimulus(2'b11, 10'd0, 8'h10, 10'd8, 8'h20);
    applyStimulus(2'b01, 10'd16, 8'h30, 10'd0, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_wb_valid", wb_valid, 1'b0);
    checkOutput("t6_wb_data", wb_data, 128'h0);
    checkOutput("t6_err", err, 1'b0);
    startInstr(8'd2, 3'd0, 1'b0, 128'h0, 128'h0);
    applyStimulus(2'b11, 10'd0, 8'h5A, 10'd8, 8'hA5);
    checkOutput("t6_new_valid", wb_valid, 1'b1);
    checkOutput("t6_new_data", wb_data, 128'hA55A);
    checkOutput("t6_new_be", wb_be, 16'h0003);
    finishCommit();

    // Same index on both lanes: lane 1 wins.
    startInstr(8'd2, 3'd0, 1'b0, 128'h0, 128'h0);
    applyStimulus(2'b11, 10'd0, 8'h11, 10'd0, 8'h22);
    checkOutput("t7_wb_data", wb_data, 128'h22);
    checkOutput("t7_wb_be", wb_be, 16'h0001);
    checkOutput("t7_err", err, 1'b0);
    finishCommit();

    // More valid lanes than remaining chunks.
    startInstr(8'd1, 3'd0, 1'b0, 128'h0, 128'h0);
    applyStimulus(2'b11, 10'd0, 8'h33, 10'd8, 8'h44);
    checkOutput("t8_wb_valid", wb_valid, 1'b1);
    checkOutput("t8_wb_data", wb_data, 128'h33);
    checkOutput("t8_wb_be", wb_be, 16'h0001);
    checkOutput("t8_err", err, 1'b1);
    finishCommit();
    checkOutput("t8_idle_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rvv_vd_collect.md
# rvv_vd_collect

Result collector on the consumer side of the vector ALU lanes. It gathers lane-width result chunks, each tagged with a bit index into the destination register, into a VLEN-bit buffer preloaded with the old destination contents. It optionally applies the v0 element mask, then presents the assembled register with byte enables to the vector register file over a valid/ready handshake. One instance serves all ALU lanes of the vector unit.

## Interface
- `VLEN`, 128: vector register width in bits; multiple of 64.
- `LANE_WIDTH`, 3: lane chunk width is W = 2^LANE_WIDTH bits (8/16/32/64).
- `NB_LANES`, 2: number of lane result ports (1..4).

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin new instruction; sampled only in IDLE.
- `nb_chunks`  in  8  number of lane chunks expected for this instruction; latched on start.
- `vsew`  in  3  element width code (SEW = 8<<vsew); latched on start.
- `mask_en`  in  1  instruction is masked (vm=0); latched on start.
- `v0`  in  VLEN  mask register; latched on start.
- `vd_old`  in  VLEN  current destination contents; loaded into the buffer on start.
- `lane_valid`  in  NB_LANES  chunk present on lane i.
- `lane_data`  in  NB_LANES*64  lane i result at [64i +: 64]; low W bits used.
- `lane_index`  in  NB_LANES*10  lane i destination bit index at [10i +: 10]; multiple of W.
- `wb_valid`  out  1  assembled register available.
- `wb_ready`  in  1  register file accepts.
- `wb_data`  out  VLEN  assembled register.
- `wb_be`  out  VLEN/8  byte enables of bytes actually written.
- `busy`  out  1  state != IDLE.
- `err`  out  1  sticky protocol error; cleared on start.

## Operation
- States: IDLE, COLLECT, COMMIT.
- IDLE, `start`=1:
  - latch parameters, buffer <= `vd_old`, be <= 0, err <= 0, remaining <= `nb_chunks`.
  - Go to COMMIT if `nb_chunks`==0, else COLLECT.
- COLLECT, per cycle, lanes processed in ascending order i=0..NB_LANES-1:
  - Each valid lane consumes one from remaining.
  - Element number e = `lane_index` >> (vsew+3).
  - Chunk written to buffer[`lane_index` +: W] and its W/8 be bits set, unless:
    - `mask_en` && v0[e]==0: dropped, counted, no be.
    - `lane_index`+W > VLEN: dropped, counted, err<=1.
  - Two lanes writing the same index in one cycle: higher lane wins.
  - Valid lanes in excess of remaining: ignored, err<=1.
  - remaining reaching 0 this cycle: go to COMMIT.
- COMMIT:
  - `wb_valid`=1; `wb_data`/`wb_be` stable.
  - `wb_valid`&&`wb_ready`: go to IDLE.
  - `lane_valid` in COMMIT or IDLE: ignored, err<=1 (err still visible during COMMIT).
- `start` outside IDLE is ignored with no error.
- Reset at any time, including mid-COLLECT or mid-COMMIT: abandons the instruction.

## Timing
- Reset values: `wb_valid`=0, `wb_data`=0, `wb_be`=0, `busy`=0, `err`=0, state IDLE.
- `start` accepted cycle N: `busy`=1 at N+1.
- Last chunk accepted cycle M: `wb_valid`=1 at M+1, with that chunk included in `wb_data`.
- `nb_chunks`=0: `wb_valid`=1 the cycle after start.
- Handshake completes cycle K: `wb_valid`=0 and `busy`=0 at K+1; the next `start` is accepted at K+1 earliest.
- Throughput: NB_LANES chunks/cycle.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `RVV_COLLECT_MASK_EN` defined: v0 masking as above.
- Undefined:
  - `mask_en` and `v0` ignored; no v0 storage.
  - Every in-range chunk written and its be bits set.

## Test plan
- Unmasked byte lanes (VLEN=128, W=8, NB_LANES=2), vsew=0, nb_chunks=16, chunks at indexes 0,8..120 with data 0x00,0x11..0xFF, two per cycle -> `wb_data`=0xFFEE..1100, `wb_be`=0xFFFF, `wb_valid` exactly 1 cycle after the 8th transfer cycle.
- Masked, vsew=1, v0=0x55, `vd_old`=all 0xAA, 16 chunks -> elements 0,2,4,6 from lanes, others 0xAAAA, `wb_be`=0x3333 (0xFFFF with macro undefined).
- Backpressure: `wb_ready` low 5 cycles in COMMIT, `start` pulsed -> `wb_valid`, `wb_data` and `wb_be` held; start ignored; IDLE the cycle after `wb_ready`=1.
- nb_chunks=0, `vd_old`=0x1234.. -> `wb_valid` next cycle, `wb_data`=`vd_old`, `wb_be`=0.
- Chunk at index 128 among 4 chunks -> counted, not written, `err`=1 through COMMIT, cleared by the next start.
- `reset` asserted mid-COLLECT after 3 of 16 chunks -> next cycle `busy`=0, `wb_valid`=0, `wb_data`=0, `err`=0; a new start then behaves normally.
